// File: rtl/decode_pkg.sv
// Shared constants and the decoded-entry layout for the pipelined decode stage.
// The entry struct is sized for the default 32-bit / 5-bit-register configuration.
package decode_pkg;

    localparam logic [1:0] FMT_A = 2'd0;
    localparam logic [1:0] FMT_B = 2'd1;
    localparam logic [1:0] FMT_C = 2'd2;

    localparam logic [5:0] OPC_NOP     = 6'b111111;
    localparam logic [5:0] OPC_B_LOAD  = 6'b100010;
    localparam logic [5:0] OPC_B_STORE = 6'b100011;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_REG_AW  = 5;

    typedef struct packed {
        logic [1:0]             fmt;
        logic                   nop;
        logic [DEF_REG_AW-1:0]  rsrc1;
        logic [DEF_REG_AW-1:0]  rsrc2;
        logic [DEF_REG_AW-1:0]  rdst;
        logic [DEF_INSTR_W-1:0] imm;
        logic [DEF_INSTR_W-1:0] opcode;
    } decode_entry_t;

endpackage

// File: rtl/decode_stage_pipelined_if.sv
// Fetch-side and execute-side handshake bundle plus debug statistics.
// The decode stage uses the slave view; its environment uses the master view.
interface decode_stage_pipelined_if #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_fmt;
    logic               out_nop;
    logic [REG_AW-1:0]  out_rsrc1;
    logic [REG_AW-1:0]  out_rsrc2;
    logic [REG_AW-1:0]  out_rdst;
    logic [INSTR_W-1:0] out_imm;
    logic [INSTR_W-1:0] out_opcode;
    logic [CNT_W-1:0]   stat_decoded;
    logic [CNT_W-1:0]   stat_nops;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_fmt, out_nop, out_rsrc1, out_rsrc2,
               out_rdst, out_imm, out_opcode, stat_decoded, stat_nops
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_fmt, out_nop, out_rsrc1, out_rsrc2,
               out_rdst, out_imm, out_opcode, stat_decoded, stat_nops
    );
endinterface

// File: rtl/decode_fields.sv
// Combinational classification of one instruction word into format a/b/c
// with register, immediate and opcode field extraction.
module decode_fields
    import decode_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int OPC_W      = 6,
    parameter int SIGN_EXT_B = 0
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [1:0]         fmt,
    output logic               nop,
    output logic [REG_AW-1:0]  rsrc1,
    output logic [REG_AW-1:0]  rsrc2,
    output logic [REG_AW-1:0]  rdst,
    output logic [INSTR_W-1:0] imm,
    output logic [INSTR_W-1:0] opcode
);
    localparam int IMMB_W = INSTR_W - 2*REG_AW - OPC_W;
    localparam int FUNC_W = INSTR_W - 3*REG_AW;

    logic [OPC_W-1:0]  op;
    logic              is_b;
    logic [IMMB_W-1:0] imm_b;
    logic              sign_b;

    assign op     = instr[OPC_W-1:0];
    // Load/store pair: top bit set, middle bits clear, bit 1 set, bit 0 free
    assign is_b   = op[OPC_W-1] && (op[OPC_W-2:2] == '0) && op[1];
    assign imm_b  = instr[INSTR_W-1-2*REG_AW : OPC_W];
    assign sign_b = (SIGN_EXT_B != 0) && imm_b[IMMB_W-1];

    always_comb begin
        fmt    = FMT_C;
        nop    = (&op) || (instr == '0);
        rsrc1  = '0;
        rsrc2  = '0;
        rdst   = '0;
        imm    = '0;
        opcode = {{(INSTR_W-OPC_W){1'b0}}, op};
        if (op == '0) begin
            fmt    = FMT_A;
            rsrc1  = instr[INSTR_W-1 -: REG_AW];
            rsrc2  = instr[INSTR_W-1-REG_AW -: REG_AW];
            rdst   = instr[INSTR_W-1-2*REG_AW -: REG_AW];
            opcode = {{(INSTR_W-FUNC_W){1'b0}}, instr[FUNC_W-1:0]};
        end else if (is_b) begin
            fmt   = FMT_B;
            rsrc1 = instr[INSTR_W-1 -: REG_AW];
            rdst  = instr[INSTR_W-1-REG_AW -: REG_AW];
            imm   = {{(INSTR_W-IMMB_W){sign_b}}, imm_b};
        end else begin
            imm = {{OPC_W{1'b0}}, instr[INSTR_W-1:OPC_W]};
        end
    end
endmodule

// File: rtl/decode_stage_pipelined.sv
// Registered decode stage: valid/ready input, DEPTH-entry circular output queue,
// flush on branch redirect and saturating accept/NOP statistics.
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int OPC_W      = 6,
    parameter int DEPTH      = 2,
    parameter int SIGN_EXT_B = 0,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    decode_stage_pipelined_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]         fmt;
        logic               nop;
        logic [REG_AW-1:0]  rsrc1;
        logic [REG_AW-1:0]  rsrc2;
        logic [REG_AW-1:0]  rdst;
        logic [INSTR_W-1:0] imm;
        logic [INSTR_W-1:0] opcode;
    } entry_t;

    entry_t           dec;
    entry_t           shown;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             run;
    logic             full;
    logic             not_empty;
    logic             accept;
    logic             push;
    logic             pop;

    decode_fields #(
        .INSTR_W    (INSTR_W),
        .REG_AW     (REG_AW),
        .OPC_W      (OPC_W),
        .SIGN_EXT_B (SIGN_EXT_B)
    ) u_fields (
        .instr  (bus.in_instr),
        .fmt    (dec.fmt),
        .nop    (dec.nop),
        .rsrc1  (dec.rsrc1),
        .rsrc2  (dec.rsrc2),
        .rdst   (dec.rdst),
        .imm    (dec.imm),
        .opcode (dec.opcode)
    );

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign not_empty = (count != '0);
    // run holds ready low until the first edge after reset is released
    assign bus.in_ready = run && (!full || bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign push      = accept && !bus.flush;
    assign pop       = not_empty && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            run <= 1'b1;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stat_decoded <= '0;
            bus.stat_nops    <= '0;
        end else if (push) begin
            if (!(&bus.stat_decoded)) bus.stat_decoded <= bus.stat_decoded + 1'b1;
            if (dec.nop && !(&bus.stat_nops)) bus.stat_nops <= bus.stat_nops + 1'b1;
        end
    end

    assign shown          = not_empty ? mem[rd_ptr] : '0;
    assign bus.out_valid  = not_empty;
    assign bus.out_fmt    = shown.fmt;
    assign bus.out_nop    = shown.nop;
    assign bus.out_rsrc1  = shown.rsrc1;
    assign bus.out_rsrc2  = shown.rsrc2;
    assign bus.out_rdst   = shown.rdst;
    assign bus.out_imm    = shown.imm;
    assign bus.out_opcode = shown.opcode;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: two instances (zero- and sign-extended
// format-b immediates, wide and 3-bit statistics) checked every cycle against a queue model.
module tb_decode_stage_pipelined;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    decode_stage_pipelined_if #(.INSTR_W(32), .REG_AW(5), .CNT_W(16)) b0 ();
    decode_stage_pipelined_if #(.INSTR_W(32), .REG_AW(5), .CNT_W(3))  b1 ();

    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
    assign b0.in_instr = in_instr;  assign b1.in_instr = in_instr;
    assign b0.flush = flush;        assign b1.flush = flush;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

    decode_stage_pipelined #(.SIGN_EXT_B(0), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    decode_stage_pipelined #(.SIGN_EXT_B(1), .CNT_W(3))  dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    // ---------------- model ----------------
    logic [31:0] q[$];
    int  st_dec0, st_nop0, st_dec1, st_nop1;
    bit  m_en;

    function automatic decode_entry_t model_dec(input logic [31:0] w, input bit sext);
        decode_entry_t e;
        logic [5:0] op;
        op = w[5:0];
        e = '0;
        e.nop = (op == 6'h3f) || (w == 32'h0);
        if (op == 6'h0) begin
            e.fmt = FMT_A; e.rsrc1 = w[31:27]; e.rsrc2 = w[26:22]; e.rdst = w[21:17];
            e.opcode = {15'd0, w[16:0]};
        end else if (op == OPC_B_LOAD || op == OPC_B_STORE) begin
            e.fmt = FMT_B; e.rsrc1 = w[31:27]; e.rdst = w[26:22];
            e.imm = sext ? {{16{w[21]}}, w[21:6]} : {16'd0, w[21:6]};
            e.opcode = {26'd0, op};
        end else begin
            e.fmt = FMT_C; e.imm = {6'd0, w[31:6]}; e.opcode = {26'd0, op};
        end
        return e;
    endfunction

    function automatic int sat_inc(input int v, input int cap);
        return (v < cap) ? v + 1 : cap;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            st_dec0 = 0; st_nop0 = 0; st_dec1 = 0; st_nop1 = 0;
            m_en = 0;
        end else begin
            bit rdy, acc, isnop;
            rdy   = m_en && (q.size() < 2 || out_ready);
            acc   = in_valid && rdy;
            isnop = (in_instr[5:0] == 6'h3f) || (in_instr == 32'h0);
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_instr);
                    st_dec0 = sat_inc(st_dec0, 65535);
                    st_dec1 = sat_inc(st_dec1, 7);
                    if (isnop) begin
                        st_nop0 = sat_inc(st_nop0, 65535);
                        st_nop1 = sat_inc(st_nop1, 7);
                    end
                end
            end
            m_en = 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input bit sext, input logic rdy, input logic vld,
                       input logic [1:0] fmt, input logic nop, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [31:0] opc, input logic [15:0] sd, input logic [15:0] sn,
                       input int esd, input int esn);
        decode_entry_t e;
        e = (q.size() > 0) ? model_dec(q[0], sext) : '0;
        chk({tag, ".in_ready"}, 64'(rdy), 64'(m_en && (q.size() < 2 || out_ready)));
        chk({tag, ".out_valid"}, 64'(vld), 64'(q.size() > 0));
        chk({tag, ".fmt"}, 64'(fmt), 64'(e.fmt));
        chk({tag, ".nop"}, 64'(nop), 64'(e.nop));
        chk({tag, ".rsrc1"}, 64'(r1), 64'(e.rsrc1));
        chk({tag, ".rsrc2"}, 64'(r2), 64'(e.rsrc2));
        chk({tag, ".rdst"}, 64'(rd), 64'(e.rdst));
        chk({tag, ".imm"}, 64'(imm), 64'(e.imm));
        chk({tag, ".opcode"}, 64'(opc), 64'(e.opcode));
        chk({tag, ".stat_decoded"}, 64'(sd), 64'(esd));
        chk({tag, ".stat_nops"}, 64'(sn), 64'(esn));
    endtask

    always @(negedge clk) begin
        cmp("d0", 1'b0, b0.in_ready, b0.out_valid, b0.out_fmt, b0.out_nop, b0.out_rsrc1,
            b0.out_rsrc2, b0.out_rdst, b0.out_imm, b0.out_opcode, b0.stat_decoded,
            b0.stat_nops, st_dec0, st_nop0);
        cmp("d1", 1'b1, b1.in_ready, b1.out_valid, b1.out_fmt, b1.out_nop, b1.out_rsrc1,
            b1.out_rsrc2, b1.out_rdst, b1.out_imm, b1.out_opcode, 16'(b1.stat_decoded),
            16'(b1.stat_nops), st_dec1, st_nop1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] vec [6] = '{
        {5'd9, 5'd2, 16'h1234, 6'b100011},
        {26'h155_5555, 6'b100001},
        {26'h0AB_CDEF, 6'b100110},
        32'hFFFF_FFFF,
        {5'd31, 5'd0, 5'd17, 17'h1_FFFF},
        {5'd1, 5'd1, 16'h8000, 6'b100010}
    };

    initial begin
        decode_entry_t pin;
        int saved;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;

        // model pins
        pin = model_dec(32'h0886_2000, 1'b0);
        chk("pin_a_rsrc1", 64'(pin.rsrc1), 64'd1);
        chk("pin_a_rdst", 64'(pin.rdst), 64'd3);
        chk("pin_a_opcode", 64'(pin.opcode), 64'h2000);
        pin = model_dec({5'd4, 5'd7, 16'hFFFE, 6'b100010}, 1'b1);
        chk("pin_b_imm_sext", 64'(pin.imm), 64'hFFFF_FFFE);
        pin = model_dec({26'h3FF_FFFF, 6'b111111}, 1'b0);
        chk("pin_c_fmt_nop", 64'({pin.fmt, pin.nop}), 64'b101);

        repeat (2) step();
        chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_stat", 64'(b0.stat_decoded), 64'd0);
        reset = 1'b0;
        chk("rst_in_ready_low", 64'(b0.in_ready), 64'd0);
        step();
        chk("in_ready_after_rst", 64'(b0.in_ready), 64'd1);

        push_one(32'h0);
        chk("zero_valid", 64'(b0.out_valid), 64'd1);
        chk("zero_fmt_nop", 64'({b0.out_fmt, b0.out_nop}), 64'b001);
        chk("zero_stats", 64'({b0.stat_decoded, b0.stat_nops}), {32'd0, 16'd1, 16'd1});

        push_one(32'h0886_2000);
        chk("a_regs", 64'({b0.out_rsrc1, b0.out_rsrc2, b0.out_rdst}), 64'({5'd1, 5'd2, 5'd3}));
        chk("a_opcode", 64'(b0.out_opcode), 64'h2000);
        chk("a_nop", 64'(b0.out_nop), 64'd0);

        push_one({5'd4, 5'd7, 16'hFFFE, 6'b100010});
        chk("b_rdst", 64'(b0.out_rdst), 64'd7);
        chk("b_imm_zext", 64'(b0.out_imm), 64'h0000_FFFE);
        chk("b_imm_sext", 64'(b1.out_imm), 64'hFFFF_FFFE);

        push_one({26'h3FF_FFFF, 6'b111111});
        chk("c_fmt_nop", 64'({b0.out_fmt, b0.out_nop}), 64'b101);
        chk("c_imm", 64'(b0.out_imm), 64'h03FF_FFFF);
        chk("c_regs", 64'({b0.out_rsrc1, b0.out_rsrc2, b0.out_rdst}), 64'd0);

        for (int i = 0; i < 6; i++) push_one(vec[i]);
        chk("sat_small_cnt", 64'(b1.stat_decoded), 64'd7);
        step();

        // back-pressure, then simultaneous push/pop at full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = {5'd11, 27'h0}; step();
        in_instr = {5'd12, 27'h0}; step();
        in_instr = {5'd13, 27'h0};
        chk("full_in_ready", 64'(b0.in_ready), 64'd0);
        step();
        chk("full_head", 64'(b0.out_rsrc1), 64'd11);
        out_ready = 1'b1;
        #1 chk("full_pop_ready", 64'(b0.in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("pushpop_head", 64'(b0.out_rsrc1), 64'd12);
        step();
        chk("order_last", 64'(b0.out_rsrc1), 64'd13);
        step();
        chk("drained", 64'(b0.out_valid), 64'd0);

        // flush with a concurrent accept
        out_ready = 1'b0;
        push_one({5'd20, 27'h0});
        push_one({5'd21, 27'h0});
        saved = st_dec0;
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1; in_instr = {5'd22, 27'h0};
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(b0.out_valid), 64'd0);
        chk("flush_stat", 64'(b0.stat_decoded), 64'(saved));

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        push_one(32'h0886_2000);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(b0.out_valid), 64'd0);
        chk("arst_fields", 64'({b0.out_rsrc1, b0.out_rsrc2, b0.out_rdst}), 64'd0);
        chk("arst_stats", 64'({b0.stat_decoded, b0.stat_nops}), 64'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        push_one({5'd4, 5'd7, 16'h7FFE, 6'b100011});
        chk("post_rst_imm", 64'(b1.out_imm), 64'h0000_7FFE);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
